// File: rtl/xfer_matrix_pkg.sv
// Shared definitions for the transfer matrix: default data width, selector
// width helper and the special source/destination selector codes.
package xfer_matrix_pkg;

  localparam int REG_WIDTH = 8;

  function automatic int sel_w(input int num_regs);
    return $clog2(num_regs) + 1;
  endfunction

  // Special codes sit directly above the register index range.
  function automatic int src_ext(input int num_regs);
    return num_regs;
  endfunction

  function automatic int src_zero(input int num_regs);
    return num_regs + 1;
  endfunction

  function automatic int dst_ext(input int num_regs);
    return num_regs;
  endfunction

endpackage

// File: rtl/xfer_matrix_src_mux.sv
// Source selector for one stage entry: register, external input or zero;
// codes above the zero code read as zero and flag an error.
module xfer_src_mux #(
  parameter int REG_WIDTH = 8,
  parameter int NUM_REGS  = 8,
  parameter int SEL_W     = 4
) (
  input  logic [NUM_REGS*REG_WIDTH-1:0] regs_i,
  input  logic [REG_WIDTH-1:0]          ext_i,
  input  logic [SEL_W-1:0]              sel_i,
  output logic [REG_WIDTH-1:0]          data_o,
  output logic                          err_o
);
  import xfer_matrix_pkg::*;

  localparam logic [SEL_W-1:0] SRC_EXT_S  = SEL_W'(src_ext(NUM_REGS));
  localparam logic [SEL_W-1:0] SRC_ZERO_S = SEL_W'(src_zero(NUM_REGS));

  always_comb begin
    data_o = '0;
    err_o  = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (sel_i == SEL_W'(r)) data_o = regs_i[r*REG_WIDTH +: REG_WIDTH];
    end
    if (sel_i == SRC_EXT_S) data_o = ext_i;
    else if (sel_i > SRC_ZERO_S) err_o = 1'b1;
  end

endmodule

// File: rtl/xfer_matrix.sv
// Multi-channel register transfer matrix: requests latch into one stage and
// write one cycle later with parallel-move semantics and lowest-index priority.
module xfer_matrix #(
  parameter int  REG_WIDTH = xfer_matrix_pkg::REG_WIDTH,
  parameter int  NUM_REGS  = 8,
  parameter int  NUM_CH    = 2,
  localparam int SEL_W     = xfer_matrix_pkg::sel_w(NUM_REGS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             xfer_valid,
  output logic [NUM_CH-1:0]             xfer_ready,
  input  logic [NUM_CH*SEL_W-1:0]       src_sel,
  input  logic [NUM_CH*SEL_W-1:0]       dst_sel,
  input  logic                          ovr_valid,
  input  logic [SEL_W-1:0]              ovr_src,
  input  logic [SEL_W-1:0]              ovr_dst,
  input  logic                          stall,
  input  logic [REG_WIDTH-1:0]          ext_in,
  output logic [REG_WIDTH-1:0]          ext_out,
  output logic                          ext_we,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_flat,
  output logic                          busy,
  output logic                          conflict,
  output logic                          sel_err
);
  import xfer_matrix_pkg::*;

  // Entry 0 is the override, entry c+1 is channel c: index order is priority.
  localparam int NUM_ENT = NUM_CH + 1;
  localparam logic [SEL_W-1:0] DST_EXT_S = SEL_W'(dst_ext(NUM_REGS));

  logic [NUM_ENT-1:0]                 stg_vld_d, stg_vld_q;
  logic [NUM_ENT-1:0][SEL_W-1:0]      stg_src_d, stg_src_q;
  logic [NUM_ENT-1:0][SEL_W-1:0]      stg_dst_d, stg_dst_q;
  logic [NUM_REGS-1:0][REG_WIDTH-1:0] regs_d, regs_q;
  logic [REG_WIDTH-1:0]               ext_out_d, ext_out_q;
  logic [NUM_ENT-1:0][REG_WIDTH-1:0]  ent_data;
  logic [NUM_ENT-1:0]                 ent_src_err;
  logic [NUM_REGS:0]                  claimed;
  logic                               wr_ext, wr_conflict, wr_sel_err;

  always_comb begin
    xfer_ready = '0;
    if (!reset && !stall) begin
      xfer_ready    = '1;
      xfer_ready[0] = ~ovr_valid;
    end
    stg_vld_d    = '0;
    stg_src_d    = '0;
    stg_dst_d    = '0;
    stg_vld_d[0] = ovr_valid & ~stall & ~reset;
    stg_src_d[0] = ovr_src;
    stg_dst_d[0] = ovr_dst;
    for (int c = 0; c < NUM_CH; c++) begin
      stg_vld_d[c+1] = xfer_valid[c] & xfer_ready[c];
      stg_src_d[c+1] = src_sel[c*SEL_W +: SEL_W];
      stg_dst_d[c+1] = dst_sel[c*SEL_W +: SEL_W];
    end
  end

  // Muxes read regs_q, i.e. state before this cycle's writes, so swaps work.
  for (genvar e = 0; e < NUM_ENT; e++) begin : g_mux
    xfer_src_mux #(
      .REG_WIDTH(REG_WIDTH),
      .NUM_REGS (NUM_REGS),
      .SEL_W    (SEL_W)
    ) u_mux (
      .regs_i(regs_q),
      .ext_i (ext_in),
      .sel_i (stg_src_q[e]),
      .data_o(ent_data[e]),
      .err_o (ent_src_err[e])
    );
  end

  always_comb begin
    regs_d      = regs_q;
    ext_out_d   = ext_out_q;
    claimed     = '0;
    wr_ext      = 1'b0;
    wr_conflict = 1'b0;
    wr_sel_err  = 1'b0;
    for (int e = 0; e < NUM_ENT; e++) begin
      if (stg_vld_q[e]) begin
        if (ent_src_err[e] || stg_dst_q[e] > DST_EXT_S) wr_sel_err = 1'b1;
        for (int t = 0; t < NUM_REGS; t++) begin
          if (stg_dst_q[e] == SEL_W'(t)) begin
            if (claimed[t]) wr_conflict = 1'b1;
            else begin
              claimed[t] = 1'b1;
              regs_d[t]  = ent_data[e];
            end
          end
        end
        if (stg_dst_q[e] == DST_EXT_S) begin
          if (claimed[NUM_REGS]) wr_conflict = 1'b1;
          else begin
            claimed[NUM_REGS] = 1'b1;
            wr_ext            = 1'b1;
            ext_out_d         = ent_data[e];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stg_vld_q <= '0;
      stg_src_q <= '0;
      stg_dst_q <= '0;
      regs_q    <= '0;
      ext_out_q <= '0;
    end else begin
      stg_vld_q <= stg_vld_d;
      stg_src_q <= stg_src_d;
      stg_dst_q <= stg_dst_d;
      regs_q    <= regs_d;
      ext_out_q <= ext_out_d;
    end
  end

  // Reset masks the stage outputs immediately, before the clearing edge.
  assign busy      = (|stg_vld_q) & ~reset;
  assign ext_we    = wr_ext & ~reset;
  assign conflict  = wr_conflict & ~reset;
  assign sel_err   = wr_sel_err & ~reset;
  assign ext_out   = reset ? '0 : ext_out_d;
  assign regs_flat = reset ? '0 : regs_q;

endmodule

// File: tb/tb_xfer_matrix.sv
// Scoreboard bench for xfer_matrix: a transfer-level model predicts each
// stage's effects; a negedge monitor compares whenever the stage is busy.
module tb_xfer_matrix;
  localparam int RW = 8;
  localparam int NR = 8;
  localparam int NC = 2;
  localparam int SW = 4;
  localparam int NE = NC + 1;

  logic              clk = 0;
  logic              reset;
  logic [NC-1:0]     xfer_valid, xfer_ready;
  logic [NC*SW-1:0]  src_sel, dst_sel;
  logic              ovr_valid;
  logic [SW-1:0]     ovr_src, ovr_dst;
  logic              stall;
  logic [RW-1:0]     ext_in, ext_out;
  logic              ext_we, busy, conflict, sel_err;
  logic [NR*RW-1:0]  regs_flat;

  xfer_matrix #(.REG_WIDTH(RW), .NUM_REGS(NR), .NUM_CH(NC)) dut (
    .clk(clk), .reset(reset), .xfer_valid(xfer_valid), .xfer_ready(xfer_ready),
    .src_sel(src_sel), .dst_sel(dst_sel), .ovr_valid(ovr_valid),
    .ovr_src(ovr_src), .ovr_dst(ovr_dst), .stall(stall), .ext_in(ext_in),
    .ext_out(ext_out), .ext_we(ext_we), .regs_flat(regs_flat), .busy(busy),
    .conflict(conflict), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            conflict;
    bit            sel_err;
    bit            ext_we;
    logic [RW-1:0] ext_out;
    logic [63:0]   regs_pre;
  } exp_t;

  exp_t          sb[$];
  logic [RW-1:0] m_regs[NR];
  logic [RW-1:0] m_ext;
  bit            p_v[NE];
  int            p_s[NE], p_d[NE];
  int            checks = 0, errors = 0;
  bit            mon_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] flat_model();
    logic [63:0] f = '0;
    for (int r = 0; r < NR; r++) f[r*RW +: RW] = m_regs[r];
    return f;
  endfunction

  function automatic logic [2*SW-1:0] pk(input int s1, input int s0);
    return {SW'(s1), SW'(s0)};
  endfunction

  // Apply last cycle's accepted transfers; ein is ext_in during the read cycle.
  task automatic process_pend(input logic [RW-1:0] ein);
    exp_t          e;
    bit            any = 0;
    bit            taken[NR+1];
    logic [RW-1:0] nxt[NR];
    logic [RW-1:0] data;
    for (int i = 0; i < NE; i++) any |= p_v[i];
    if (!any) return;
    e.regs_pre = flat_model();
    e.conflict = 0; e.sel_err = 0; e.ext_we = 0;
    nxt = m_regs;
    for (int t = 0; t <= NR; t++) taken[t] = 0;
    for (int i = 0; i < NE; i++) begin
      if (!p_v[i]) continue;
      if (p_s[i] < NR) data = m_regs[p_s[i]];
      else if (p_s[i] == NR) data = ein;
      else data = '0;
      if (p_s[i] > NR + 1) e.sel_err = 1;
      if (p_d[i] > NR) e.sel_err = 1;
      else if (taken[p_d[i]]) e.conflict = 1;
      else begin
        taken[p_d[i]] = 1;
        if (p_d[i] == NR) begin e.ext_we = 1; m_ext = data; end
        else nxt[p_d[i]] = data;
      end
    end
    e.ext_out = m_ext;
    m_regs = nxt;
    sb.push_back(e);
  endtask

  task automatic cyc(input bit rst, input bit stl, input logic [NC-1:0] v,
                     input logic [NC*SW-1:0] s, input logic [NC*SW-1:0] d,
                     input bit ov, input int os, input int od, input logic [RW-1:0] ein);
    @(posedge clk); #1;
    reset = rst; stall = stl; xfer_valid = v; src_sel = s; dst_sel = d;
    ovr_valid = ov; ovr_src = SW'(os); ovr_dst = SW'(od); ext_in = ein;
    if (rst) begin
      for (int r = 0; r < NR; r++) m_regs[r] = '0;
      m_ext = '0;
    end else process_pend(ein);
    for (int i = 0; i < NE; i++) p_v[i] = 0;
    if (!rst && !stl) begin
      if (ov) begin p_v[0] = 1; p_s[0] = os; p_d[0] = od; end
      for (int c = 0; c < NC; c++) begin
        if (v[c] && !(c == 0 && ov)) begin
          p_v[c+1] = 1;
          p_s[c+1] = int'(s[c*SW +: SW]);
          p_d[c+1] = int'(d[c*SW +: SW]);
        end
      end
    end
  endtask

  task automatic idle(input int n, input logic [RW-1:0] ein);
    repeat (n) cyc(0, 0, '0, '0, '0, 0, 0, 0, ein);
  endtask

  // Monitor: mid-cycle sampling of readiness and of the stage's effects.
  initial begin
    exp_t          e;
    logic [NC-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_rdy = '1;
        if (reset || stall) exp_rdy = '0;
        else if (ovr_valid) exp_rdy[0] = 1'b0;
        chk("xfer_ready", xfer_ready, exp_rdy);
        chk("busy", busy, sb.size() > 0);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("conflict", conflict, e.conflict);
          chk("sel_err", sel_err, e.sel_err);
          chk("ext_we", ext_we, e.ext_we);
          chk("ext_out", ext_out, e.ext_out);
          chk("regs_pre", regs_flat, e.regs_pre);
        end else begin
          chk("idle_pulses", {conflict, sel_err, ext_we}, 3'b000);
        end
      end
    end
  end

  initial begin
    logic [NC-1:0]    rv;
    logic [NC*SW-1:0] rs, rd;
    reset = 1; stall = 0; xfer_valid = '0; src_sel = '0; dst_sel = '0;
    ovr_valid = 0; ovr_src = '0; ovr_dst = '0; ext_in = '0;
    for (int i = 0; i < NE; i++) p_v[i] = 0;
    cyc(1, 0, '0, '0, '0, 0, 0, 0, 8'h00);
    cyc(1, 0, '0, '0, '0, 0, 0, 0, 8'h00);
    mon_en = 1;
    chk("reset_regs", regs_flat, 64'h0);
    chk("reset_outs", {busy, conflict, sel_err, ext_we, xfer_ready, ext_out}, '0);

    // ext -> reg2, accepted in the first cycle out of reset
    cyc(0, 0, 2'b01, pk(0, NR), pk(0, 2), 0, 0, 0, 8'hA5);
    idle(2, 8'hA5);
    chk("ext_to_reg2", regs_flat[2*RW +: RW], 8'hA5);

    // load reg1/reg2/reg3 back-to-back, then swap reg1<->reg2 in one stage
    cyc(0, 0, 2'b01, pk(0, NR), pk(0, 1), 0, 0, 0, 8'h00);
    cyc(0, 0, 2'b11, pk(NR, NR), pk(3, 2), 0, 0, 0, 8'h11);
    cyc(0, 0, 2'b11, pk(2, 1), pk(1, 2), 0, 0, 0, 8'h22);
    idle(2, 8'h7E);
    chk("swap_reg1", regs_flat[1*RW +: RW], 8'h22);
    chk("swap_reg2", regs_flat[2*RW +: RW], 8'h11);

    // zero source vs ext source to reg3: channel 0 wins
    cyc(0, 0, 2'b11, pk(NR, NR + 1), pk(3, 3), 0, 0, 0, 8'h00);
    idle(2, 8'h7E);
    chk("conflict_reg3", regs_flat[3*RW +: RW], 8'h00);

    // override reg4 -> ext while channel 0 is requesting reg1 -> reg5
    cyc(0, 0, 2'b01, pk(0, NR), pk(0, 4), 0, 0, 0, 8'h00);
    cyc(0, 0, 2'b01, pk(0, 1), pk(0, 5), 1, 4, NR, 8'h3C);
    idle(2, 8'h00);
    chk("ovr_ext_out", ext_out, 8'h3C);
    chk("ovr_blocks_ch0", regs_flat[5*RW +: RW], 8'h00);

    // in-flight request dropped by reset; bad destination raises sel_err
    cyc(0, 0, 2'b01, pk(0, NR), pk(0, 6), 0, 0, 0, 8'h5A);
    cyc(1, 0, '0, '0, '0, 0, 0, 0, 8'h5A);
    idle(1, 8'h5A);
    chk("reset_drop", regs_flat, 64'h0);
    cyc(0, 0, 2'b01, pk(0, NR), pk(0, NR + 3), 0, 0, 0, 8'h99);
    idle(2, 8'h99);
    chk("bad_dst_regs", regs_flat, 64'h0);
    chk("bad_dst_ext", ext_out, 8'h00);

    // stall with continuous valid: in-flight completes, nothing new accepted
    cyc(0, 0, 2'b11, pk(NR, NR), pk(2, 1), 0, 0, 0, 8'h10);
    cyc(0, 1, 2'b11, pk(NR, NR), pk(2, 1), 0, 0, 0, 8'h20);
    cyc(0, 1, 2'b11, pk(NR, NR), pk(2, 1), 0, 0, 0, 8'h21);
    cyc(0, 1, 2'b11, pk(NR, NR), pk(2, 1), 0, 0, 0, 8'h22);
    chk("stall_hold_reg1", regs_flat[1*RW +: RW], 8'h20);
    cyc(0, 0, 2'b11, pk(NR, NR), pk(2, 1), 0, 0, 0, 8'h23);
    idle(2, 8'h40);
    chk("stall_resume_reg1", regs_flat[1*RW +: RW], 8'h40);
    chk("stall_resume_reg2", regs_flat[2*RW +: RW], 8'h40);

    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NC; c++) begin
        rs[c*SW +: SW] = SW'($urandom_range(0, NR + 3));
        rd[c*SW +: SW] = ($urandom_range(0, 9) == 0) ? SW'($urandom_range(NR + 1, 15))
                                                    : SW'($urandom_range(0, NR));
      end
      rv = NC'($urandom);
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0, rv, rs, rd,
          $urandom_range(0, 4) == 0, $urandom_range(0, NR + 3),
          $urandom_range(0, NR + 1), RW'($urandom));
    end

    idle(3, 8'h00);
    for (int r = 0; r < NR; r++) chk($sformatf("final_reg%0d", r), regs_flat[r*RW +: RW], m_regs[r]);
    chk("final_ext_out", ext_out, m_ext);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xfer_matrix.md
XFER_MATRIX -- requirements
Module: xfer_matrix

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8, data width of every register and bus.
REQ-002 SHALL have parameter NUM_REGS, default 8, register-file depth (>=2).
REQ-003 SHALL have parameter NUM_CH, default 2, number of parallel transfer channels (>=1).
REQ-004 SHALL derive localparam SEL_W = clog2(NUM_REGS)+1 as the selector width.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port xfer_valid  input  NUM_CH  per-channel request.
REQ-008 SHALL have port xfer_ready  output  NUM_CH  per-channel acceptance.
REQ-009 SHALL have port src_sel  input  NUM_CH*SEL_W  per-channel source; channel c in bits [c*SEL_W +: SEL_W].
REQ-010 SHALL have port dst_sel  input  NUM_CH*SEL_W  per-channel destination, same packing.
REQ-011 SHALL have ports ovr_valid  input  1, ovr_src  input  SEL_W, ovr_dst  input  SEL_W: the priority override request.
REQ-012 SHALL have port stall  input  1  freezes acceptance.
REQ-013 SHALL have port ext_in  input  REG_WIDTH  external data source.
REQ-014 SHALL have ports ext_out  output  REG_WIDTH and ext_we  output  1: external write.
REQ-015 SHALL have port regs_flat  output  NUM_REGS*REG_WIDTH  all registers; register r in [r*REG_WIDTH +: REG_WIDTH].
REQ-016 SHALL have ports busy  output  1, conflict  output  1, sel_err  output  1.

Function
REQ-017 Source index 0..NUM_REGS-1 SHALL select that register; NUM_REGS selects ext_in; NUM_REGS+1 selects 8'h00 (zero); any higher index SHALL yield zero and set sel_err.
REQ-018 Destination index 0..NUM_REGS-1 SHALL write that register; NUM_REGS writes ext_out with a one-cycle ext_we pulse; any higher index SHALL drop the write and set sel_err.
REQ-019 xfer_ready[c] SHALL be 1 when stall=0, except xfer_ready[0]=0 while ovr_valid=1.
REQ-020 A request SHALL be accepted in cycle N when valid and ready are both 1; ovr_valid is accepted in any cycle with stall=0 and occupies channel 0's slot.
REQ-021 Accepted requests SHALL be latched into a single stage; the write SHALL take effect at the rising edge ending cycle N+1 (latency 2 edges).
REQ-022 Source values SHALL be read in cycle N+1 from register state before that cycle's writes (parallel-move semantics: swap A<->B in one stage is legal).
REQ-023 Two or more stage entries with the same valid destination SHALL resolve to the lowest channel index (override counts as channel 0); losers are dropped and conflict pulses 1 for one cycle.
REQ-024 stall=1 SHALL accept nothing but SHALL NOT hold back an already-latched stage, which still completes.
REQ-025 busy SHALL equal 1 whenever the stage holds at least one valid entry.
REQ-026 sel_err and conflict SHALL be single-cycle pulses aligned with the write cycle; ext_out SHALL hold its last written value.
REQ-027 Back-to-back requests every cycle SHALL be sustained with no bubble (throughput one transfer per channel per cycle).

Reset
REQ-028 While reset=1 all registers, ext_out and the stage SHALL clear to 0; xfer_ready, ext_we, busy, conflict, sel_err SHALL be 0.
REQ-029 A request in flight when reset asserts SHALL be discarded, never written.
REQ-030 The first request SHALL be accepted in the first cycle after reset deasserts.

Structure
REQ-031 SEL_W derivation helper and the special source/destination indices (SRC_EXT, SRC_ZERO, DST_EXT) SHALL live in the shared package, alongside REG_WIDTH.
REQ-032 Per-channel source selection SHALL be one sub-module, xfer_src_mux, instantiated NUM_CH+1 times.

Verification
REQ-033 Reset, then ch0 src=NUM_REGS (ext_in=8'hA5) dst=2 -> regs_flat reg2=8'hA5 two edges after acceptance, busy high exactly one cycle.
REQ-034 reg1=8'h11, reg2=8'h22; ch0 1->2 and ch1 2->1 same cycle -> reg1=8'h22, reg2=8'h11.
REQ-035 ch0 src=NUM_REGS+1 dst=3 and ch1 ext dst=3 with ext_in=8'h7E -> reg3=8'h00, conflict pulse 1 cycle.
REQ-036 ovr_valid with ovr_src=4 dst=NUM_REGS (reg4=8'h3C) while ch0 valid -> xfer_ready[0]=0, ext_we pulse, ext_out=8'h3C.
REQ-037 Accept a request, assert reset next cycle -> target register stays 0; separate case with dst=NUM_REGS+3 -> sel_err pulse, no write.
REQ-038 stall=1 for 3 cycles with continuous valid -> xfer_ready=0, in-flight stage completes, no new writes until stall drops.
